// File: rtl/point_add_arbiter.sv
// Round-robin arbiter that shares one point_add instance between two requesters,
// pulsing the adder reset to start it, bounding its run time, and acknowledging the winner.
module point_add_arbiter #(
   // Default coordinate width covers one GF(3^97) element (97 trits at 2 bits) plus one.
   parameter int unsigned W      = 195,
   parameter logic [15:0] SETTLE = 16'd2,
   parameter logic [15:0] TMO    = 16'hFFFF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0,
   input  logic [2*W:0]   p1_0,
   input  logic [2*W:0]   p2_0,
   input  logic           req1,
   input  logic [2*W:0]   p1_1,
   input  logic [2*W:0]   p2_1,
   output logic           ack0,
   output logic           ack1,
   output logic           err,
   output logic [2*W:0]   res,
   output logic           busy,
   output logic           add_rst,
   output logic [2*W:0]   add_p1,
   output logic [2*W:0]   add_p2,
   input  logic           add_done,
   input  logic [2*W:0]   add_res
);

   localparam int unsigned PW = 2 * W + 1;
   localparam logic [PW-1:0] POINT_INF = {{(PW - 1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_START = 4'b0010,
      S_WAIT  = 4'b0100,
      S_DONE  = 4'b1000
   } state_e;

   state_e        state_q, state_d;
   logic          rr_q, rr_d;
   logic          gnt_q, gnt_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          err_q, err_d;
   logic [PW-1:0] res_q, res_d;
   logic [PW-1:0] p1_q, p1_d;
   logic [PW-1:0] p2_q, p2_d;

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
      res_d   = res_q;
      p1_d    = p1_q;
      p2_d    = p2_q;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // On a tie the requester that was not served last wins.
               gnt_d   = (req0 && req1) ? ~rr_q : req1;
               rr_d    = gnt_d;
               p1_d    = gnt_d ? p1_1 : p1_0;
               p2_d    = gnt_d ? p2_1 : p2_0;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done is ignored for the first SETTLE cycles: the adder's done and
            // condition registers may still hold values from before its reset.
            if (cnt_q >= SETTLE && add_done) begin
               res_d   = add_res;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               state_d = S_DONE;
            end else if (cnt_q == TMO - 16'd1) begin
               res_d   = POINT_INF;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so every flop samples
      // the values from before this edge, regardless of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         rr_q    <= 1'b1;
         gnt_q   <= 1'b0;
         cnt_q   <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
         // NOTE: the wide data registers are reset too, so the adder never sees
         // stale operands and res reads as zero until the first acknowledge.
         res_q   <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
         res_q   <= res_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
      end
   end

   // The adder is held in reset everywhere except WAIT; both are state decodes.
   assign add_rst = (state_q != S_WAIT);
   assign busy    = (state_q != S_IDLE);
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign err     = err_q;
   assign res     = res_q;
   assign add_p1  = p1_q;
   assign add_p2  = p2_q;

endmodule

// File: doc/point_add_arbiter.md
Name: point_add_arbiter

Overview:
- Shares one point_add instance between two requesters, for example two scalar-multiplication sequencers or a scalar multiplier and a host port.
- Arbitrates between them round-robin and latches the granted operands onto the adder inputs.
- Starts the adder by pulsing its reset, waits for its done, and returns the result with a one-cycle acknowledge to the winner.
- A watchdog aborts a hung operation.

Parameters:
- W, `WIDTH+1, bit width of one GF(3^97) coordinate in the codebase encoding.
- SETTLE, 2, minimum WAIT cycles before add_done is trusted; masks stale done/condition registers in the adder after its reset.
- TMO, 16'hFFFF, WAIT-cycle limit before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req0  in  1  request from requester 0; held high until ack0
- p1_0  in  2W+1  operand P1 of requester 0, packed {x,y,zero}
- p2_0  in  2W+1  operand P2 of requester 0, packed {x,y,zero}
- req1, p1_1, p2_1  in  1, 2W+1, 2W+1  same for requester 1
- ack0  out  1  one-cycle pulse; res valid for requester 0
- ack1  out  1  one-cycle pulse; res valid for requester 1
- err  out  1  pulses with ack when the operation timed out
- res  out  2W+1  shared result {x3,y3,zero3}; held until next ack
- busy  out  1  high in START, WAIT and DONE
- add_rst  out  1  drives the adder reset input
- add_p1  out  2W+1  registered P1 to adder
- add_p2  out  2W+1  registered P2 to adder
- add_done  in  1  adder done
- add_res  in  2W+1  adder result {x3,y3,zero3}

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE, ack0=ack1=err=0, res=0, add_p1=add_p2=0, busy=0.
  - rr pointer=1, so requester 0 wins the first tie. WAIT counter=0.
  - No ack is issued for an aborted operation.
- States, one-hot registered: IDLE, START, WAIT, DONE.
- add_rst = 1 in every state except WAIT. The adder runs only while WAIT is active.
- IDLE:
  - Sample req0/req1. If only one is high, grant it. If both are high, grant the requester not equal to rr.
  - At the grant edge: latch that requester's p1/p2 into add_p1/add_p2, record gnt id, set rr=gnt, go to START.
  - With no request, stay in IDLE.
- START: one cycle with add_rst=1 and operands stable; then go to WAIT, clearing the counter.
- WAIT:
  - add_rst=0; the counter increments each cycle.
  - If counter>=SETTLE and add_done=1: at the edge, res<=add_res, assert ack[gnt] (err=0), go to DONE.
  - Else if counter==TMO-1: res<={0,0,1} (point at infinity), assert ack[gnt] and err, go to DONE.
  - add_done takes priority over timeout in the same cycle.
- DONE: the ack (and err, if set) is high for exactly this one cycle; next state is IDLE.
- Requester contract:
  - Operands are only sampled at the grant edge, so requesters may change them after grant.
  - req must be low in the cycle after ack. A registered requester clears req on seeing ack, which meets this.
  - A req still high in that IDLE cycle is a new request.
  - req dropped before ack: the operation still completes and acks; the requester ignores it.
- Fairness: after requester k is served, the other requester wins any tie. Continuous requests from both alternate 0,1,0,1.
- Minimum latency:
  - Grant edge, then START.
  - WAIT ≥ SETTLE+1 cycles.
  - DONE, then IDLE.
- Throughput: at most one operation per (SETTLE + adder latency + 4) cycles.
- Outputs: all are registered or one-hot state decodes; no combinational path from req to ack.
- Adder interface: add_p1/add_p2 never change while in WAIT, because the adder compares and uses its inputs continuously.

Test Plan:
- Single add with point at infinity: req0 with P1.zero=1, P2=(0,1) -> ack0 one cycle with res={0,1,0}, ack1=0, err=0; busy falls the cycle after ack0; add_rst low only during WAIT.
- Simultaneous first requests: req0 and req1 in the same cycle after reset -> requester 0 served first (ack0), then requester 1 (ack1); add_rst high ≥2 cycles between the two WAIT windows.
- Fairness: req0 re-asserted immediately after each ack while req1 is held -> ack order 0,1,0,1 over four operations.
- Negation: P1=(0,1), P2=(0,2) -> res zero bit=1, err=0. Doubling P1=P2=(0,1) -> res equals the software model's 2P.
- Reset mid-WAIT: reset during WAIT cycle 5 -> no ack, add_rst=1 and busy=0 the next cycle; a subsequent req1 completes normally.
- Watchdog: TMO=8 with a stub adder holding add_done=0 -> ack plus err in DONE after 8 WAIT cycles, res={0,0,1}; a later operation with a working adder has err=0.
